// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: RAM map, message-schedule FSM states, sigma functions.
package sha256_pkg;

  // RAM map: H init words, K constant table, default message-schedule base
  localparam int unsigned H_BASE         = 0;
  localparam int unsigned K_BASE         = 64;
  localparam int unsigned W_BASE_DEFAULT = 128;

  // Message-schedule controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_FIN    = 2'd3
  } sched_state_e;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sched_window.sv
// 16x32 shift window holding the most recent schedule words W[t-1]..W[t-16].
module sched_window (
  input  logic        clk,
  input  logic        shift_en,
  input  logic [31:0] din,
  output logic [31:0] tap_t2,
  output logic [31:0] tap_t7,
  output logic [31:0] tap_t15,
  output logic [31:0] tap_t16
);

  // win[0] is the newest word (W[t-1]), win[15] the oldest (W[t-16])
  logic [31:0] win [16];

  // Shift a new word in at the head when enabled; contents need no reset
  always_ff @(posedge clk) begin
    if (shift_en) begin
      win[0] <= din;
      for (int unsigned i = 1; i < 16; i++) begin
        win[i] <= win[i-1];
      end
    end
  end

  assign tap_t2  = win[1];
  assign tap_t7  = win[6];
  assign tap_t15 = win[14];
  assign tap_t16 = win[15];

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads W[0..15] from RAM, expands W[16..63] back to RAM.
module msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned W_BASE = W_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        COPY_DONE,
  output logic        BUSY,
  output logic        DONE,
  output logic        MEM_RE,
  output logic        MEM_WR_N,
  output logic [7:0]  MEM_ADDR,
  input  logic [31:0] MEM_DIN,
  output logic [31:0] MEM_DOUT,
  output logic        MEM_DOE
);

  localparam logic [7:0] BASE = 8'(W_BASE);

  sched_state_e state_q;
  logic [6:0]   cnt_q;
  logic         win_shift;
  logic [31:0]  win_din;
  logic [31:0]  w_new;
  logic [31:0]  tap_t2, tap_t7, tap_t15, tap_t16;

  sched_window u_window (
    .clk      (CLK),
    .shift_en (win_shift),
    .din      (win_din),
    .tap_t2   (tap_t2),
    .tap_t7   (tap_t7),
    .tap_t15  (tap_t15),
    .tap_t16  (tap_t16)
  );

  // Adder tree for the next schedule word
  assign w_new = sig1(tap_t2) + tap_t7 + sig0(tap_t15) + tap_t16;

  // Window feed and write-data drive, decoded from the current state
  always_comb begin
    win_shift = 1'b0;
    win_din   = w_new;
    MEM_DOUT  = '0;
    case (state_q)
      ST_LOAD: begin
        // read data lags MEM_RE by one cycle, so c=0 has nothing to capture
        win_shift = (cnt_q != 7'd0);
        win_din   = MEM_DIN;
      end
      ST_EXPAND: begin
        win_shift = 1'b1;
        MEM_DOUT  = w_new;
      end
      default: ;
    endcase
  end

  // Controller FSM with registered bus-control outputs.
  // One counter serves both phases: LOAD ends at c=16, which is exactly
  // the first EXPAND index t=16, so the count carries straight across.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      MEM_RE   <= 1'b0;
      MEM_WR_N <= 1'b1;
      MEM_DOE  <= 1'b0;
      MEM_ADDR <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START && COPY_DONE) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            BUSY     <= 1'b1;
            MEM_RE   <= 1'b1;
            MEM_ADDR <= BASE;
          end
        end
        ST_LOAD: begin
          if (cnt_q == 7'd16) begin
            state_q  <= ST_EXPAND;
            MEM_RE   <= 1'b0;
            MEM_WR_N <= 1'b0;
            MEM_DOE  <= 1'b1;
            MEM_ADDR <= BASE + 8'd16;
          end else begin
            cnt_q    <= cnt_q + 7'd1;
            MEM_RE   <= (cnt_q < 7'd15);
            MEM_ADDR <= (cnt_q < 7'd15) ? BASE + 8'(cnt_q) + 8'd1 : '0;
          end
        end
        ST_EXPAND: begin
          if (cnt_q == 7'd63) begin
            state_q  <= ST_FIN;
            cnt_q    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            MEM_WR_N <= 1'b1;
            MEM_DOE  <= 1'b0;
            MEM_ADDR <= '0;
          end else begin
            cnt_q    <= cnt_q + 7'd1;
            MEM_ADDR <= BASE + 8'(cnt_q) + 8'd1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          DONE    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule with a behavioural RAM and a write scoreboard.
module tb_msg_schedule;

  localparam int unsigned W_BASE = 128;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        COPY_DONE = 1'b0;
  logic        BUSY, DONE, MEM_RE, MEM_WR_N, MEM_DOE;
  logic [7:0]  MEM_ADDR;
  logic [31:0] MEM_DIN = '0;
  logic [31:0] MEM_DOUT;

  logic [31:0] ram  [256];
  logic [31:0] snap [256];
  logic [31:0] run1 [48];
  logic [31:0] blk  [16];
  logic [39:0] exp_q [$];
  logic [39:0] mon_e;

  int passes = 0;
  int total = 0;
  int wr_count = 0;
  bit overlap = 1'b0;
  bit doe_bad = 1'b0;

  msg_schedule #(.W_BASE(W_BASE)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .COPY_DONE (COPY_DONE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .MEM_RE    (MEM_RE),
    .MEM_WR_N  (MEM_WR_N),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DIN   (MEM_DIN),
    .MEM_DOUT  (MEM_DOUT),
    .MEM_DOE   (MEM_DOE)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM; the memory manager is held in reset along with the block
  always @(posedge CLK) begin
    if (MEM_RE) MEM_DIN <= ram[MEM_ADDR];
    if (!MEM_WR_N && RST_N) ram[MEM_ADDR] <= MEM_DOUT;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Put blk into RAM and queue the 48 expected writes
  task automatic load_block();
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) begin
      w[i] = blk[i];
      ram[W_BASE + i] = blk[i];
    end
    for (int t = 16; t < 64; t++) begin
      w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
      exp_q.push_back({8'(W_BASE + t), w[t]});
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge CLK) begin
    #2;
    if (MEM_RE && !MEM_WR_N) overlap = 1'b1;
    if (MEM_DOE && MEM_WR_N) doe_bad = 1'b1;
    if (RST_N && !MEM_WR_N) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(MEM_ADDR), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(MEM_ADDR), 32'(mon_e[39:32]));
        chk("wr_data", MEM_DOUT, mon_e[31:0]);
        chk("wr_doe", 32'(MEM_DOE), 32'd1);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_done"}, 32'(DONE), 32'd0);
    chk({tag, "_re"},   32'(MEM_RE), 32'd0);
    chk({tag, "_wr_n"}, 32'(MEM_WR_N), 32'd1);
    chk({tag, "_doe"},  32'(MEM_DOE), 32'd0);
    chk({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
    chk({tag, "_dout"}, MEM_DOUT, 32'd0);
  endtask

  // Window k lies between edges E(k-1) and Ek; START is sampled at E0.
  // repulse_k: START pulse sampled at E<repulse_k> plus a COPY_DONE drop.
  // reset_k: RST_N low sampled at E<reset_k>, run aborted afterwards.
  task automatic run_block(input int repulse_k, input int reset_k);
    wr_count = 0;
    @(negedge CLK); #1;
    START = 1'b1;
    COPY_DONE = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      @(negedge CLK); #1;
      START = (k == repulse_k);
      if (repulse_k != 0 && k == 5) COPY_DONE = 1'b0;
      if (reset_k != 0 && k == reset_k) RST_N = 1'b0;
      if (reset_k != 0 && k == reset_k + 1) begin
        chk_reset_outputs("abort");
        RST_N = 1'b1;
        break;
      end
      if (k == 1) begin
        chk("e1_busy", 32'(BUSY), 32'd1);
        chk("e1_re", 32'(MEM_RE), 32'd1);
        chk("e1_addr", 32'(MEM_ADDR), W_BASE);
        chk("e1_done", 32'(DONE), 32'd0);
      end
      if (k == 18) chk("e18_wr_n", 32'(MEM_WR_N), 32'd0);
      if (k == 65) begin
        chk("e65_busy", 32'(BUSY), 32'd1);
        chk("e65_done", 32'(DONE), 32'd0);
      end
      if (k == 66) begin
        chk("e66_done", 32'(DONE), 32'd1);
        chk("e66_busy", 32'(BUSY), 32'd0);
        chk("write_count", 32'(wr_count), 32'd48);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
      end
    end
  endtask

  initial begin
    bit any_busy, any_re, any_wr;
    int bad;

    for (int i = 0; i < 256; i++) ram[i] = $urandom;

    // Reset state
    repeat (3) @(negedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST_N = 1'b1;

    // START without COPY_DONE must be ignored
    COPY_DONE = 1'b0;
    START = 1'b1;
    any_busy = 1'b0; any_re = 1'b0; any_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      any_busy |= BUSY;
      any_re   |= MEM_RE;
      any_wr   |= !MEM_WR_N;
    end
    START = 1'b0;
    chk("nocopy_busy", 32'(any_busy), 32'd0);
    chk("nocopy_re", 32'(any_re), 32'd0);
    chk("nocopy_wr", 32'(any_wr), 32'd0);

    // "abc" padded block
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    load_block();
    run_block(0, 0);
    chk("abc_w16", ram[144], 32'h6162_6380);
    chk("abc_w17", ram[145], 32'h000F_0000);

    // All-ones block exercises mod-2^32 wrap
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFF_FFFF;
    load_block();
    run_block(0, 0);
    chk("ones_w16", ram[144], 32'h203F_FFFC);

    // START re-pulse and COPY_DONE drop mid-run
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block();
    run_block(30, 0);

    // Reset at E40 aborts with no further writes
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block();
    for (int i = 0; i < 256; i++) snap[i] = ram[i];
    run_block(0, 40);
    exp_q.delete();
    chk("abort_write_count", 32'(wr_count), 32'd22);
    repeat (3) @(negedge CLK);
    #1;
    chk("abort_idle_wr_n", 32'(MEM_WR_N), 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if ((i < 128 || (i >= 166 && i < 192)) && ram[i] !== snap[i]) bad++;
    end
    chk("abort_ram_untouched", 32'(bad), 32'd0);

    // Back-to-back runs: second START sampled at E67 of the first
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    load_block();
    run_block(0, 0);
    for (int i = 0; i < 48; i++) run1[i] = ram[144 + i];
    load_block();
    run_block(0, 0);
    bad = 0;
    for (int i = 0; i < 48; i++) if (ram[144 + i] !== run1[i]) bad++;
    chk("b2b_identical", 32'(bad), 32'd0);

    @(negedge CLK); #3;
    chk("re_wr_overlap", 32'(overlap), 32'd0);
    chk("doe_without_write", 32'(doe_bad), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 SHALL have parameter W_BASE, default 128: RAM address of W[0]; legal range 128..192.
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port START  input  1  request expansion of the 16 words at W_BASE..W_BASE+15.
REQ-005 SHALL have port COPY_DONE  input  1  ROM-to-RAM constant copy finished; from memory manager COPY_ROM_COMPLETE.
REQ-006 SHALL have port BUSY  output  1  high in LOAD and EXPAND.
REQ-007 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-008 SHALL have port MEM_RE  output  1  RAM read strobe.
REQ-009 SHALL have port MEM_WR_N  output  1  RAM write enable, active-low.
REQ-010 SHALL have port MEM_ADDR  output  8  RAM word address.
REQ-011 SHALL have port MEM_DIN  input  32  RAM read data, valid one cycle after MEM_RE.
REQ-012 SHALL have port MEM_DOUT  output  32  RAM write data.
REQ-013 SHALL have port MEM_DOE  output  1  high when MEM_DOUT drives the shared 32-bit data bus.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> EXPAND -> FIN -> IDLE.
REQ-015 SHALL leave IDLE only when START=1 and COPY_DONE=1 at the same edge; otherwise remain in IDLE.
REQ-016 SHALL ignore START outside IDLE.
REQ-017 LOAD SHALL last 17 cycles, counter c=0..16; cycles c=0..15 assert MEM_RE with MEM_ADDR=W_BASE+c; cycles c=1..16 shift MEM_DIN into a 16x32 window.
REQ-018 EXPAND SHALL last 48 cycles, t=16..63, one word per cycle: W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32.
REQ-019 s0(x) SHALL be ROTR7^ROTR18^SHR3; s1(x) SHALL be ROTR17^ROTR19^SHR10.
REQ-020 In each EXPAND cycle, the block SHALL drive MEM_WR_N=0, MEM_DOE=1, MEM_ADDR=W_BASE+t, MEM_DOUT=W[t], and shift W[t] into the window.
REQ-021 MEM_RE and MEM_WR_N=0 SHALL never be asserted in the same cycle.
REQ-022 MEM_DOE SHALL be 0 outside EXPAND.
REQ-023 FIN SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-024 Timing: START sampled at edge E0 -> LOAD E1..E17, EXPAND E18..E65, DONE high E66, BUSY high E1..E65.
REQ-025 SHALL never write addresses 0..7 (H init) or 64..127 (K table).
REQ-026 Address arithmetic SHALL be 8-bit with no wrap; W_BASE>192 is illegal and not supported.
REQ-027 SHALL ignore a COPY_DONE fall during LOAD or EXPAND.

Reset
REQ-028 When RST_N=0 at a rising edge, the next state SHALL be IDLE, with BUSY=0, DONE=0, MEM_RE=0, MEM_WR_N=1, MEM_DOE=0, MEM_ADDR=0, MEM_DOUT=0, and counters at 0.
REQ-029 Reset mid-LOAD or mid-EXPAND SHALL abort with no further RAM access; window contents are don't-care.
REQ-030 Window registers SHALL need no reset.

Structure
REQ-031 Shared package sha256_pkg SHALL hold: H_BASE=0, K_BASE=64, W_BASE default 128, the FSM state enum, and the s0/s1 functions.
REQ-032 The 16x32 shift window SHALL be sub-module sched_window, with load/shift enable, serial input, and taps [t-2], [t-7], [t-15], [t-16].
REQ-033 The top level SHALL contain the FSM, counters, adder tree and bus drive.

Verification
REQ-034 Bench SHALL cover the "abc" block: W[0]=0x61626380, W[1..14]=0, W[15]=0x00000018, START -> RAM[128+16]=0x61626380, RAM[128+17]=0x000F0000, DONE at E66.
REQ-035 Bench SHALL cover the all-ones block: W[0..15]=0xFFFFFFFF -> RAM[144]=0x203FFFFC (mod-2^32 wrap).
REQ-036 Bench SHALL cover START=1 with COPY_DONE=0 for 10 cycles -> BUSY stays 0, MEM_RE=0, MEM_WR_N=1 throughout.
REQ-037 Bench SHALL cover START re-pulsed at E30 -> no restart, DONE still at E66, exactly 48 writes.
REQ-038 Bench SHALL cover RST_N=0 at E40 (t=38) -> next cycle IDLE, all outputs at reset values, RAM[166..191] unchanged, RAM[0..127] unchanged.
REQ-039 Bench SHALL cover two back-to-back runs (START at E67) -> second run identical results; MEM_RE and MEM_WR_N=0 never overlap.
